code_player: RTL

CODE_PLAYER -- requirements
Module: code_player

---
 rtl/code_player.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/code_player.sv
// -----------------------------------------------------------------------------
// code_player
//   Plays a latched code as a train of one-cycle button-press pulses, LSB
//   first. Each symbol becomes a pulse on b0_out (symbol 0) or b1_out
//   (symbol 1). Consecutive pulses are separated by GAP idle cycles. A single
//   done pulse follows normal completion. abort drops back to IDLE. reset_n
//   abandons any sequence at once.
//
// Parameters
//   MAX_LEN : maximum symbols per sequence (2..15)
//   GAP     : idle cycles between consecutive pulses (>= 1)
//
// Ports
//   clk          in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   play request, honoured only in IDLE
//   abort        in   terminate the current sequence
//   code         in   MAX_LEN symbols, bit i played i-th
//   code_len     in   number of symbols, clamped to MAX_LEN
//   b0_out       out  press pulse for symbol 0
//   b1_out       out  press pulse for symbol 1
//   busy         out  high in every non-IDLE state
//   done         out  one-cycle pulse on normal completion
//   hex_display  out  symbols emitted in the current/last sequence
// -----------------------------------------------------------------------------
module code_player #(
    parameter int MAX_LEN = 8,
    parameter int GAP     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] code,
    input  logic [3:0]         code_len,
    output logic               b0_out,
    output logic               b1_out,
    output logic               busy,
    output logic               done,
    output logic [3:0]         hex_display
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    // The gap counter is loaded with GAP-1 and counts down to zero.
    localparam int          GW    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [3:0]  MAX_L = 4'(MAX_LEN);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    state_t               r_state;
    logic [MAX_LEN-1:0]   r_shift;
    logic [3:0]           r_len;
    logic [3:0]           r_count;
    logic [GW-1:0]        r_gap_cnt;

    state_t               w_state;
    logic [MAX_LEN-1:0]   w_shift;
    logic [3:0]           w_len;
    logic [3:0]           w_count;
    logic [GW-1:0]        w_gap_cnt;
    logic [3:0]           w_count_inc;

    assign w_count_inc = r_count + 4'd1;

    // Next-state and datapath update.
    // NOTE: every signal assigned here gets its hold value first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_len     = r_len;
        w_count   = r_count;
        w_gap_cnt = r_gap_cnt;

        unique case (r_state)
            S_IDLE: begin
                // abort outranks start while idle.
                if (start && !abort) begin
                    w_count = 4'd0;
                    if (code_len == 4'd0) begin
                        w_state = S_DONE;
                    end else begin
                        w_shift = code;
                        w_len   = (code_len > MAX_L) ? MAX_L : code_len;
                        w_state = S_PULSE;
                    end
                end
            end

            S_PULSE: begin
                // The pulse is already on the outputs this cycle, so it is
                // counted even when abort arrives alongside it.
                w_count = w_count_inc;
                if (abort) begin
                    w_state = S_IDLE;
                end else if (w_count_inc == r_len) begin
                    w_state = S_DONE;
                end else begin
                    w_state   = S_GAP;
                    w_gap_cnt = GAP_LOAD;
                end
            end

            S_GAP: begin
                if (abort) begin
                    w_state = S_IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_shift = r_shift >> 1;
                    w_state = S_PULSE;
                end else begin
                    w_gap_cnt = r_gap_cnt - GW'(1);
                end
            end

            S_DONE: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    // NOTE: the shift register is small and fully reset so an abandoned code
    // never leaks into the next sequence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_len     <= 4'd0;
            r_count   <= 4'd0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state;
            r_shift   <= w_shift;
            r_len     <= w_len;
            r_count   <= w_count;
            r_gap_cnt <= w_gap_cnt;
        end
    end

    // Outputs are decoded from registers only, so reset clears them at once.
    assign b0_out      = (r_state == S_PULSE) && !r_shift[0];
    assign b1_out      = (r_state == S_PULSE) &&  r_shift[0];
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign hex_display = (r_count > MAX_L) ? MAX_L : r_count;

endmodule
